// File: rtl/vdp_pkg.sv
// vdp_pkg: shared VDP geometry, sprite-draw sequencer states and VDP command codes
package vdp_pkg;

    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;
    localparam int VRAM_AW  = 8;

    localparam logic [1:0] VDP_CMD_NOP = 2'd0;
    localparam logic [1:0] VDP_CMD_CLS = 2'd1;
    localparam logic [1:0] VDP_CMD_DRW = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_RD_L,
        S_CAP_L,
        S_WR_L,
        S_RD_H,
        S_CAP_H,
        S_WR_H,
        S_NEXT,
        S_CLR,
        S_DONE
    } draw_state_t;

    // Sprite bytes are MSB-leftmost while VRAM is LSB-leftmost
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = b[7 - i];
        return v;
    endfunction

endpackage

// File: rtl/sprite_aligner.sv
// sprite_aligner: maps one sprite row onto two VRAM bytes; DRAW_WRAP_EN selects wrap instead of clip
module sprite_aligner
    import vdp_pkg::*;
(
    input  logic [7:0]         i_byte,
    input  logic [5:0]         i_sx,
    input  logic [4:0]         i_sy,
    input  logic [3:0]         i_row,
    output logic [7:0]         o_p_lo,
    output logic [7:0]         o_p_hi,
    output logic [VRAM_AW-1:0] o_addr_lo,
    output logic [VRAM_AW-1:0] o_addr_hi,
    output logic               o_row_clip,
    output logic               o_hi_skip
);

    logic [15:0] w_pat;
    logic [4:0]  w_row;
    logic [2:0]  w_col_lo;
    logic [2:0]  w_col_hi;

    // Shift the reversed byte into pixel position and split it across two columns
    always_comb begin
        w_pat    = {8'h00, bit_rev8(i_byte)} << i_sx[2:0];
        w_col_lo = i_sx[5:3];
        w_col_hi = w_col_lo + 3'd1;
`ifdef DRAW_WRAP_EN
        w_row      = i_sy + {1'b0, i_row};
        o_row_clip = 1'b0;
        o_hi_skip  = i_sx[2:0] == 3'd0;
`else
        {o_row_clip, w_row} = {1'b0, i_sy} + {2'b00, i_row};
        o_hi_skip  = (i_sx[2:0] == 3'd0) || (w_col_lo == 3'd7);
`endif
        o_p_lo    = w_pat[7:0];
        o_p_hi    = w_pat[15:8];
        o_addr_lo = {w_row, w_col_lo};
        o_addr_hi = {w_row, w_col_hi};
    end

endmodule

// File: rtl/sprite_draw_ctrl.sv
// sprite_draw_ctrl: CHIP-8 DRW/CLS sequencer doing XOR read-modify-write on VDP VRAM (DRAW_WRAP_EN: wrap instead of clip)
module sprite_draw_ctrl
    import vdp_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic [7:0]         i_draw_x,
    input  logic [7:0]         i_draw_y,
    input  logic [3:0]         i_draw_n,
    input  logic [11:0]        i_sprite_addr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_collision,
    output logic               o_mem_req,
    output logic [11:0]        o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [7:0]         i_mem_rdata,
    output logic               o_vram_req,
    input  logic               i_vram_gnt,
    output logic               o_vram_we,
    output logic [VRAM_AW-1:0] o_vram_addr,
    output logic [7:0]         o_vram_wdata,
    input  logic [7:0]         i_vram_rdata
);

    draw_state_t        r_state;
    logic [5:0]         r_sx;
    logic [4:0]         r_sy;
    logic [3:0]         r_n;
    logic [11:0]        r_base;
    logic [3:0]         r_row;
    logic [7:0]         r_byte;
    logic               r_busy;
    logic               r_done;
    logic               r_coll;
    logic               r_mem_req;
    logic [11:0]        r_mem_addr;
    logic               r_vram_req;
    logic               r_vram_we;
    logic [VRAM_AW-1:0] r_vram_addr;
    logic [7:0]         r_vram_wdata;

    logic [7:0]         w_p_lo;
    logic [7:0]         w_p_hi;
    logic [VRAM_AW-1:0] w_addr_lo;
    logic [VRAM_AW-1:0] w_addr_hi;
    logic               w_row_clip;
    logic               w_hi_skip;
    logic [3:0]         w_row_nxt;
    logic               w_unused;

    assign w_row_nxt = r_row + 4'd1;
    assign w_unused  = ^{i_draw_x[7:6], i_draw_y[7:5]};

    sprite_aligner u_align (
        .i_byte     (r_byte),
        .i_sx       (r_sx),
        .i_sy       (r_sy),
        .i_row      (r_row),
        .o_p_lo     (w_p_lo),
        .o_p_hi     (w_p_hi),
        .o_addr_lo  (w_addr_lo),
        .o_addr_hi  (w_addr_hi),
        .o_row_clip (w_row_clip),
        .o_hi_skip  (w_hi_skip)
    );

    // Sequencer: fetch each row then XOR it into one or two VRAM bytes, or sweep VRAM to zero for a clear
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_sx         <= '0;
            r_sy         <= '0;
            r_n          <= '0;
            r_base       <= '0;
            r_row        <= '0;
            r_byte       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_coll       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_vram_req   <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_clear) begin
                        r_state      <= S_CLR;
                        r_busy       <= 1'b1;
                        r_coll       <= 1'b0;
                        r_vram_req   <= 1'b1;
                        r_vram_we    <= 1'b1;
                        r_vram_addr  <= '0;
                        r_vram_wdata <= '0;
                    end else if (i_start) begin
                        r_sx   <= i_draw_x[5:0];
                        r_sy   <= i_draw_y[4:0];
                        r_n    <= i_draw_n;
                        r_base <= i_sprite_addr;
                        r_row  <= '0;
                        r_coll <= 1'b0;
                        r_busy <= 1'b1;
                        if (i_draw_n == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FETCH;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= i_sprite_addr;
                        end
                    end
                end
                S_FETCH: begin
                    if (i_mem_ack) begin
                        r_byte    <= i_mem_rdata;
                        r_mem_req <= 1'b0;
                        if (w_row_clip) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_state     <= S_RD_L;
                            r_vram_req  <= 1'b1;
                            r_vram_we   <= 1'b0;
                            r_vram_addr <= w_addr_lo;
                        end
                    end
                end
                S_RD_L: begin
                    if (i_vram_gnt) begin
                        r_vram_req <= 1'b0;
                        r_state    <= S_CAP_L;
                    end
                end
                S_CAP_L: begin
                    r_coll       <= r_coll | (|(i_vram_rdata & w_p_lo));
                    r_vram_req   <= 1'b1;
                    r_vram_we    <= 1'b1;
                    r_vram_wdata <= i_vram_rdata ^ w_p_lo;
                    r_state      <= S_WR_L;
                end
                S_WR_L: begin
                    if (i_vram_gnt) begin
                        r_vram_we <= 1'b0;
                        if (w_hi_skip) begin
                            r_vram_req <= 1'b0;
                            r_state    <= S_NEXT;
                        end else begin
                            r_vram_addr <= w_addr_hi;
                            r_state     <= S_RD_H;
                        end
                    end
                end
                S_RD_H: begin
                    if (i_vram_gnt) begin
                        r_vram_req <= 1'b0;
                        r_state    <= S_CAP_H;
                    end
                end
                S_CAP_H: begin
                    r_coll       <= r_coll | (|(i_vram_rdata & w_p_hi));
                    r_vram_req   <= 1'b1;
                    r_vram_we    <= 1'b1;
                    r_vram_wdata <= i_vram_rdata ^ w_p_hi;
                    r_state      <= S_WR_H;
                end
                S_WR_H: begin
                    if (i_vram_gnt) begin
                        r_vram_req <= 1'b0;
                        r_vram_we  <= 1'b0;
                        r_state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_row <= w_row_nxt;
                    if (w_row_nxt == r_n) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_base + {8'h00, w_row_nxt};
                    end
                end
                S_CLR: begin
                    // one idle cycle after the last write lets it retire before DONE
                    if (!r_vram_req) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (i_vram_gnt) begin
                        if (&r_vram_addr) begin
                            r_vram_req <= 1'b0;
                            r_vram_we  <= 1'b0;
                        end else begin
                            r_vram_addr <= r_vram_addr + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_collision  = r_coll;
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_vram_req   = r_vram_req;
    assign o_vram_we    = r_vram_we;
    assign o_vram_addr  = r_vram_addr;
    assign o_vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// tb_sprite_draw_ctrl: directed checks of sprite_draw_ctrl against hand-computed VRAM contents and latencies
module tb_sprite_draw_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  draw_x = '0;
    logic [7:0]  draw_y = '0;
    logic [3:0]  draw_n = '0;
    logic [11:0] sprite_addr = '0;
    logic        busy, done, collision, mem_req, vram_req, vram_we;
    logic [11:0] mem_addr;
    logic [7:0]  vram_addr, vram_wdata, mem_rdata;
    logic [7:0]  vram_rdata = '0;
    logic        ack_en = 1'b1;
    logic        gnt_en = 1'b1;
    logic        fill = 1'b0;
    logic [7:0]  fill_val = '0;
    logic [7:0]  vram [256];
    logic [7:0]  smem [4096];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = smem[mem_addr];

    // VRAM slave: bulk fill on request, otherwise serve granted reads and writes
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) vram[i] <= fill_val;
        end else if (vram_req && gnt_en) begin
            if (vram_we) begin
                vram[vram_addr] <= vram_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                vram_rdata <= vram[vram_addr];
            end
        end
    end

    sprite_draw_ctrl dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_clear       (clear),
        .i_draw_x      (draw_x),
        .i_draw_y      (draw_y),
        .i_draw_n      (draw_n),
        .i_sprite_addr (sprite_addr),
        .o_busy        (busy),
        .o_done        (done),
        .o_collision   (collision),
        .o_mem_req     (mem_req),
        .o_mem_addr    (mem_addr),
        .i_mem_ack     (ack_en),
        .i_mem_rdata   (mem_rdata),
        .o_vram_req    (vram_req),
        .i_vram_gnt    (gnt_en),
        .o_vram_we     (vram_we),
        .o_vram_addr   (vram_addr),
        .o_vram_wdata  (vram_wdata),
        .i_vram_rdata  (vram_rdata)
    );

    task automatic issue(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [11:0] a, output int t);
        start = s; clear = c; draw_x = x; draw_y = y; draw_n = n; sprite_addr = a;
        @(posedge clk); #1;
        t = cyc;
        start = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_done(input int t, input int lim, output int d);
        d = -1;
        for (int i = 0; i < lim; i++) begin
            if (done) begin
                d = cyc - t;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        start = 1'b1; draw_n = 4'd1; fill = 1'b1; fill_val = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        fill = 1'b0;
        n_tot++; if ({busy, done, collision, mem_req, vram_req, vram_we} !== 6'b0) $display("FAIL reset_ctrl got %b want 000000", {busy, done, collision, mem_req, vram_req, vram_we}); else n_pass++;
        n_tot++; if ({mem_addr, vram_addr, vram_wdata} !== 28'h0) $display("FAIL reset_data got %h want 0", {mem_addr, vram_addr, vram_wdata}); else n_pass++;
        start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        n_tot++; if ({busy, mem_req} !== 2'b00) $display("FAIL start_in_reset got %b want 00", {busy, mem_req}); else n_pass++;
    endtask

    task automatic test_draw(input logic [7:0] exp_v, input logic exp_c, input string nm);
        int t, d;
        issue(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h200, t);
        n_tot++; if (busy !== 1'b1 || mem_addr !== 12'h200) $display("FAIL %s_accept got busy=%b addr=%h want 1 200", nm, busy, mem_addr); else n_pass++;
        wait_done(t, 50, d);
        n_tot++; if (d !== 5) $display("FAIL %s_latency got %0d want 5", nm, d); else n_pass++;
        n_tot++; if (collision !== exp_c) $display("FAIL %s_coll got %b want %b", nm, collision, exp_c); else n_pass++;
        n_tot++; if (vram[0] !== exp_v) $display("FAIL %s_vram got %h want %h", nm, vram[0], exp_v); else n_pass++;
        @(posedge clk); #1;
        n_tot++; if ({done, busy} !== 2'b00) $display("FAIL %s_idle got %b want 00", nm, {done, busy}); else n_pass++;
    endtask

    task automatic test_n_zero;
        int t, d;
        issue(1'b1, 1'b0, 8'd3, 8'd3, 4'd0, 12'h200, t);
        wait_done(t, 10, d);
        n_tot++; if (d !== 0) $display("FAIL nzero_latency got %0d want 0", d); else n_pass++;
        n_tot++; if (collision !== 1'b0) $display("FAIL nzero_coll got %b want 0", collision); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        int t, d, w0, bad;
        fill_val = 8'hA5; fill = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        w0 = wr_cnt;
        issue(1'b1, 1'b1, 8'd5, 8'd5, 4'd3, 12'h200, t);
        wait_done(t, 400, d);
        n_tot++; if (d !== 257) $display("FAIL clear_latency got %0d want 257", d); else n_pass++;
        n_tot++; if (collision !== 1'b0) $display("FAIL clear_coll got %b want 0", collision); else n_pass++;
        n_tot++; if (wr_cnt - w0 !== 256) $display("FAIL clear_writes got %0d want 256", wr_cnt - w0); else n_pass++;
        bad = 0;
        for (int i = 0; i < 256; i++) if (vram[i] !== 8'h00) bad++;
        n_tot++; if (bad !== 0) $display("FAIL clear_bytes got %0d nonzero want 0", bad); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_unaligned;
        int t, d;
        issue(1'b1, 1'b0, 8'd3, 8'd4, 4'd1, 12'h600, t);
        wait_done(t, 50, d);
        n_tot++; if (d !== 8) $display("FAIL unal_latency got %0d want 8", d); else n_pass++;
        n_tot++; if ({vram[8'h20], vram[8'h21]} !== 16'h0804) $display("FAIL unal_vram got %h want 0804", {vram[8'h20], vram[8'h21]}); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clip;
        int t, d, exp_d;
        logic [7:0] e_f8, e_07, e_00;
`ifdef DRAW_WRAP_EN
        exp_d = 16; e_f8 = 8'h1F; e_07 = 8'hE0; e_00 = 8'h1F;
`else
        exp_d = 7; e_f8 = 8'h00; e_07 = 8'h00; e_00 = 8'h00;
`endif
        issue(1'b1, 1'b0, 8'd125, 8'd63, 4'd2, 12'h300, t);
        wait_done(t, 60, d);
        n_tot++; if (d !== exp_d) $display("FAIL clip_latency got %0d want %0d", d, exp_d); else n_pass++;
        n_tot++; if (vram[8'hFF] !== 8'hE0) $display("FAIL clip_ff got %h want e0", vram[8'hFF]); else n_pass++;
        n_tot++; if ({vram[8'hF8], vram[8'h07], vram[8'h00]} !== {e_f8, e_07, e_00}) $display("FAIL clip_other got %h want %h", {vram[8'hF8], vram[8'h07], vram[8'h00]}, {e_f8, e_07, e_00}); else n_pass++;
        n_tot++; if (collision !== 1'b0) $display("FAIL clip_coll got %b want 0", collision); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_mem_wait;
        int t, d;
        ack_en = 1'b0;
        issue(1'b1, 1'b0, 8'd16, 8'd3, 4'd1, 12'h500, t);
        @(posedge clk); #1;
        n_tot++; if (mem_req !== 1'b1 || mem_addr !== 12'h500) $display("FAIL memwait_hold got req=%b addr=%h want 1 500", mem_req, mem_addr); else n_pass++;
        ack_en = 1'b1;
        wait_done(t, 50, d);
        n_tot++; if (d !== 6) $display("FAIL memwait_latency got %0d want 6", d); else n_pass++;
        n_tot++; if (vram[8'h1A] !== 8'hF0) $display("FAIL memwait_vram got %h want f0", vram[8'h1A]); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_gnt_stall;
        int t, d;
        gnt_en = 1'b0;
        issue(1'b1, 1'b0, 8'd8, 8'd2, 4'd1, 12'h400, t);
        @(posedge clk); #1;
        n_tot++; if ({vram_req, vram_we, vram_addr} !== {2'b10, 8'h11}) $display("FAIL stall_rd got %b want 1000010001", {vram_req, vram_we, vram_addr}); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            @(posedge clk); #1;
            n_tot++; if ({vram_req, vram_we, vram_addr} !== {2'b10, 8'h11}) $display("FAIL stall_hold%0d got %b want 1000010001", i, {vram_req, vram_we, vram_addr}); else n_pass++;
        end
        start = 1'b0;
        gnt_en = 1'b1;
        wait_done(t, 50, d);
        n_tot++; if (d !== 8) $display("FAIL stall_latency got %0d want 8", d); else n_pass++;
        n_tot++; if (vram[8'h11] !== 8'hC3 || collision !== 1'b0) $display("FAIL stall_result got %h/%b want c3/0", vram[8'h11], collision); else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_tot++; if ({busy, mem_req} !== 2'b00) $display("FAIL busy_start_ignored got %b want 00", {busy, mem_req}); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) smem[i] = 8'h00;
        smem[12'h200] = 8'h80;
        smem[12'h300] = 8'hFF;
        smem[12'h301] = 8'hFF;
        smem[12'h400] = 8'hC3;
        smem[12'h500] = 8'h0F;
        smem[12'h600] = 8'h81;
        test_reset();
        test_draw(8'h01, 1'b0, "draw1");
        test_draw(8'h00, 1'b1, "redraw");
        test_n_zero();
        test_clear();
        test_unaligned();
        test_clip();
        test_mem_wait();
        test_gnt_stall();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sprite_draw_ctrl.md
# sprite_draw_ctrl

Sequencer that executes CHIP-8 sprite draws (DRW) and screen clears against the 256-byte VDP video RAM. It fetches sprite bytes from main memory, aligns them to the 64x32 display, and performs read-modify-write XOR on VRAM through an arbitrated port that yields to the display scan reader. It also reports the collision flag (VF) at completion. It sits between the CPU core, which issues draw requests, and the VDP's VRAM port arbiter.

## Interface
Parameters: none (geometry fixed by package constants).

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  draw request; accepted only in IDLE
- clear  in  1  clear-screen request; accepted only in IDLE; wins over start if both high
- draw_x  in  8  sprite X origin (pixels)
- draw_y  in  8  sprite Y origin (pixels)
- draw_n  in  4  row count 0..15
- sprite_addr  in  12  main-memory address of first sprite byte (I register)
- busy  out  1  high from accept cycle+1 until done cycle inclusive
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid with done, held until next accept
- mem_req  out  1  sprite byte read request
- mem_addr  out  12  sprite byte address
- mem_ack  in  1  read data valid this cycle; may be same cycle as mem_req
- mem_rdata  in  8  sprite byte
- vram_req  out  1  VRAM access request
- vram_gnt  in  1  access performed this cycle
- vram_we  out  1  1 = write, 0 = read
- vram_addr  out  8  {row[4:0], col[2:0]}
- vram_wdata  out  8  write data
- vram_rdata  in  8  read data, valid cycle after read grant

## Operation
- On accept: latch sx = draw_x mod 64, sy = draw_y mod 32, n, sprite_addr; clear collision; row r = 0.
- VRAM bit k of byte col = pixel 8*col+k (LSB leftmost). Sprite bytes are MSB-leftmost and must be bit-reversed to s'.
- Pattern p[15:0] = s' << sx[2:0]. Low byte goes to column sx[5:3], high byte to column sx[5:3]+1.
- States: IDLE, FETCH, RD_L, CAP_L, WR_L, RD_H, CAP_H, WR_H, NEXT, CLR, DONE.
- FETCH: mem_req=1, mem_addr = sprite_addr+r (12-bit wrap). When mem_ack is sampled, latch byte. If the row is clipped, go to NEXT; otherwise go to RD_L.
- RD_x: vram_req=1, we=0; leave on vram_gnt. CAP_x: capture old = vram_rdata; collision |= |(old & pat). WR_x: vram_req=1, we=1, wdata = old ^ pat; leave on vram_gnt.
- The high byte (RD_H..WR_H) is skipped when sx[2:0]==0 or when the high column is clipped.
- Clipping (macro off): row clipped if sy+r ≥ 32; high column clipped if sx[5:3]==7.
- NEXT: r++. If r==n go to DONE, else go to FETCH. If n==0, go IDLE→DONE directly with collision=0.
- CLR: sequentially write 0x00 to addresses 0..255. Each write holds until vram_gnt. Then DONE. collision=0.
- DONE: done=1 for one cycle, then IDLE.
- addr/we/wdata stay stable while vram_req is high and vram_gnt is low. mem_addr stays stable while mem_req is high and mem_ack is low.
- start/clear while busy are ignored (not queued).

## Timing
- Reset values: busy=0, done=0, collision=0, mem_req=0, vram_req=0, vram_we=0, mem_addr=0, vram_addr=0, vram_wdata=0, state IDLE.
- A reset mid-operation aborts immediately. There is no partial-row completion guarantee.
- Accept at cycle T (start sampled in IDLE). FETCH is at T+1.
- With mem_ack and vram_gnt tied high: an aligned row takes 5 cycles and an unaligned row takes 8. done is at T+1+5n (aligned) or T+1+8n (unaligned, no clipping).
- Clear with vram_gnt always high: done at T+1+256+1.
- Each wait cycle on mem_ack or vram_gnt adds exactly one cycle.

## Configuration
- DRAW_WRAP_EN defined: clipping is disabled.
  - Rows use (sy+r) mod 32.
  - The high byte for sx[5:3]==7 goes to column 0 of the same row.
- DRAW_WRAP_EN undefined: clipping as in Operation. Clipped portions do not affect collision.

## Structure
- Package vdp_pkg holds:
  - SCREEN_W=64, SCREEN_H=32, VRAM_AW=8.
  - The draw state enum.
  - VDP command constants shared with the VDP.
- Sub-module sprite_aligner (combinational) takes the sprite byte, sx, sy and r. It returns:
  - p_lo, p_hi
  - addr_lo, addr_hi
  - row_clip, hi_skip

## Test plan
- Reset then idle: all outputs 0. start with reset low is ignored.
- Draw x=0, y=0, n=1, byte 0x80, grants tied high: write 0x01 to addr 0x00; done at T+6; collision=0.
- Repeat the same draw: addr 0x00 becomes 0x00, collision=1.
- x=61, y=31, n=2, bytes 0xFF/0xFF.
  - Macro off: row 31 gets col7=0xE0 only; row 32 is clipped.
  - Macro on: additionally col0 of row 31 = 0x1F, and row 0 is written.
- vram_gnt low for 3 cycles during RD_L: vram_addr and we stay stable; done is delayed by exactly 3.
- clear asserted together with start: screen is cleared, all 256 bytes read 0, done at T+258, collision=0.
